spi_frame_tx: RTL and testbench
===============================

# spi_frame_tx

SPI controller (initiator) that generates the 16-bit frames consumed by the chip's SPI register peripheral. It lets a test harness or on-chip sequencer write and read that peripheral without bit-banging. It accepts one frame at a time: R/W bit, 7-bit address, 8-bit data. It drives nCS/SCLK/COPI in SPI mode 0, captures CIPO during the data phase, and reports completion.

## Interface
- CLK_DIV, default 4: system clocks per SCLK half-period (H); legal range 2..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a frame; accepted only on a cycle where ready=1.
- rw  input  1  1=write, 0=read; sampled with start.
- addr  input  7  register address; sampled with start.
- wdata  input  8  write data; sampled with start (shifted out for reads too).
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse at end of frame.
- rdata  output  8  data captured from CIPO on last read frame.
- ncs  output  1  chip select, active low.
- sclk  output  1  serial clock, idles low.
- copi  output  1  controller-out serial data, MSB first.
- cipo  input  1  controller-in serial data.

## Operation
- Frame: shift register = {rw, addr[6:0], wdata[7:0]}, bit 15 first.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: ready=1, ncs=1, sclk=0, copi=0. On start&&ready: latch frame and go to SETUP; ncs=0, copi=bit15, ready=0 from the next cycle.
- SETUP: H cycles, sclk=0. Then go to SHIFT.
- SHIFT: 16 bit periods, each sclk high H cycles then low H cycles.
  - On the clk edge where sclk goes 0->1, sample cipo into a capture shift register (MSB first).
  - On the edge where sclk goes 1->0, copi advances to the next bit, except after bit 0.
  - After the 16th fall, go to HOLD.
- HOLD: H cycles, sclk=0, copi holds bit 0; then ncs=1, copi=0, go to GAP.
- GAP: H cycles with ncs=1. On exit: ready=1 and done=1 for exactly that cycle; state IDLE.
- rdata: on the done cycle, if the latched rw=0, load the last 8 captured bits. If rw=1, rdata is unchanged.
- start while ready=0 is ignored; it is not queued.
- Inputs rw/addr/wdata may change freely after acceptance.
- Half-period counter: clog2(CLK_DIV) bits, counts 0..CLK_DIV-1. Bit counter: 5 bits.

## Timing
- Reset values: ready=1, done=0, rdata=0x00, ncs=1, sclk=0, copi=0; FSM=IDLE; counters=0.
- rst asserted mid-frame: on the next edge all outputs take reset values. No done pulse; the partial frame is abandoned.
- Accept edge to ncs falling: 1 cycle.
- ncs low duration: 34·H cycles (H setup + 32·H shift + H hold).
- ncs high before ready: H cycles.
- Accept to done: 35·H + 1 cycles (H=4: 141).
- Minimum ncs high between back-to-back frames: H + 1 cycles (start held high continuously).
- COPI stable for ≥H cycles before and after every SCLK rising edge.

## Test plan
- Write, H=4: addr=0x00, wdata=0xFF, rw=1 -> COPI bits sampled on SCLK rises = 1,0000000,11111111. Exactly 16 rises; ncs low 136 cycles; done 141 cycles after accept; rdata stays 0x00.
- Read: rw=0, addr=0x04, CIPO model drives 0xA5 on the data phase (updated on SCLK falls) -> after done, rdata=0xA5. Address bits on COPI = 0000100.
- Busy start: pulse start at cycles 10 and 70 after the first accept -> only one frame; exactly one done; ready=0 throughout.
- Back-to-back: start held high, two different frames queued by the testbench -> two frames, each correct. ncs high between them = 5 cycles (H=4); two done pulses.
- Reset mid-frame: assert rst during bit 6 of SHIFT -> next cycle ncs=1, sclk=0, copi=0, ready=1, done never pulses. A following write of 0x5A completes correctly.
- CLK_DIV=2: write addr=0x7F, wdata=0x3C -> ncs low 68 cycles; COPI pattern 1,1111111,00111100.

Source files
------------

// File: rtl/spi_frame_tx_if.sv
// Host-side request/response bundle for the SPI frame initiator.
interface spi_frame_tx_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  ready, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output ready, done, rdata
    );
endinterface

// File: rtl/spi_frame_tx.sv
// SPI mode-0 initiator emitting one 16-bit {rw, addr, wdata} frame per request and
// capturing CIPO into rdata on read frames.
module spi_frame_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    spi_frame_tx_if.slave host,
    output logic          ncs,
    output logic          sclk,
    output logic          copi,
    input  logic          cipo
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [4:0]      bit_q;
    logic [14:0]     sh_q;
    logic [7:0]      cap_q;
    logic            rw_q;
    logic            ready_q;
    logic            done_q;
    logic [7:0]      rdata_q;
    logic            ncs_q;
    logic            sclk_q;
    logic            copi_q;
    logic            cnt_end;

    assign cnt_end    = (cnt_q == CntMax);
    assign host.ready = ready_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
    assign ncs        = ncs_q;
    assign sclk       = sclk_q;
    assign copi       = copi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cap_q   <= '0;
            rw_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (host.start) begin
                        // copi carries the rw bit; sh_q holds the 15 bits still to send
                        sh_q    <= {host.addr, host.wdata};
                        rw_q    <= host.rw;
                        copi_q  <= host.rw;
                        ncs_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_end) begin
                        sclk_q  <= 1'b1;
                        cap_q   <= {cap_q[6:0], cipo};
                        bit_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_end) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (bit_q != 5'd15) begin
                                copi_q <= sh_q[14];
                                sh_q   <= {sh_q[13:0], 1'b0};
                            end
                        end else if (bit_q == 5'd15) begin
                            state_q <= StHold;
                        end else begin
                            bit_q  <= bit_q + 5'd1;
                            sclk_q <= 1'b1;
                            cap_q  <= {cap_q[6:0], cipo};
                        end
                    end
                end
                StHold: begin
                    if (cnt_end) begin
                        ncs_q   <= 1'b1;
                        copi_q  <= 1'b0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (cnt_end) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        if (!rw_q) begin
                            rdata_q <= cap_q;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: CLK_DIV=4 and CLK_DIV=2 instances, directed and
// random frames compared against a frame-level reference model.
module tb_spi_frame_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_frame_tx_if bus_a ();
    spi_frame_tx_if bus_b ();

    logic       start_drv;
    logic       rw_drv;
    logic [6:0] addr_drv;
    logic [7:0] wdata_drv;
    bit         d_sel;
    logic       cipo_v = 1'b0;
    logic       ncs_a, sclk_a, copi_a, ncs_b, sclk_b, copi_b;

    assign bus_a.start = start_drv & ~d_sel;
    assign bus_a.rw    = rw_drv;
    assign bus_a.addr  = addr_drv;
    assign bus_a.wdata = wdata_drv;
    assign bus_b.start = start_drv & d_sel;
    assign bus_b.rw    = rw_drv;
    assign bus_b.addr  = addr_drv;
    assign bus_b.wdata = wdata_drv;

    spi_frame_tx #(.CLK_DIV(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .host (bus_a),
        .ncs  (ncs_a),
        .sclk (sclk_a),
        .copi (copi_a),
        .cipo (cipo_v)
    );

    spi_frame_tx #(.CLK_DIV(2)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .host (bus_b),
        .ncs  (ncs_b),
        .sclk (sclk_b),
        .copi (copi_b),
        .cipo (cipo_v)
    );

    logic       s_ncs, s_sclk, s_copi, s_ready, s_done;
    logic [7:0] s_rdata;
    assign s_ncs   = d_sel ? ncs_b : ncs_a;
    assign s_sclk  = d_sel ? sclk_b : sclk_a;
    assign s_copi  = d_sel ? copi_b : copi_a;
    assign s_ready = d_sel ? bus_b.ready : bus_a.ready;
    assign s_done  = d_sel ? bus_b.done : bus_a.done;
    assign s_rdata = d_sel ? bus_b.rdata : bus_a.rdata;

    int          nvec = 0;
    int          nerr = 0;
    int          rises, ncs_low, done_cnt, bad_ready, hi_run, last_hi_run;
    logic [15:0] rise_bits;
    logic [15:0] cipo_word = 16'h0;
    logic        p_ncs = 1'b1;
    logic        p_sclk = 1'b0;
    logic [7:0]  rdata_m [2];

    // Bus observer and CIPO target model, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (s_sclk && !p_sclk) begin
            rise_bits = {rise_bits[14:0], s_copi};
            rises++;
        end
        if (!s_sclk && p_sclk && rises < 16) cipo_v = cipo_word[15 - rises];
        if (!s_ncs && p_ncs) begin
            cipo_v      = cipo_word[15];
            last_hi_run = hi_run;
            hi_run      = 0;
        end
        if (!s_ncs) ncs_low++;
        else hi_run++;
        if (s_done) done_cnt++;
        if (!s_ncs && s_ready) bad_ready++;
        p_ncs  = s_ncs;
        p_sclk = s_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rises     = 0;
        rise_bits = '0;
        ncs_low   = 0;
        done_cnt  = 0;
        bad_ready = 0;
    endtask

    // Entered on the negedge right after the accept edge.
    task automatic wait_done(input bit busy, output int lat);
        lat = 1;
        while (s_done !== 1'b1 && lat < 600) begin
            if (busy) start_drv = (lat == 10 || lat == 70);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_frame(input bit r, input logic [6:0] a, input logic [7:0] w,
                               input int lat);
        int h;
        h = d_sel ? 2 : 4;
        chk("accept_to_done", lat, 35 * h + 1);
        chk("sclk_rises", rises, 16);
        chk("copi_bits", rise_bits, {r, a, w});
        chk("ncs_low_cycles", ncs_low, 34 * h);
        chk("done_pulses", done_cnt, 1);
        chk("ready_while_busy", bad_ready, 0);
        if (!r) rdata_m[d_sel] = cipo_word[7:0];
        chk("rdata", s_rdata, rdata_m[d_sel]);
    endtask

    task automatic do_frame(input bit r, input logic [6:0] a, input logic [7:0] w,
                            input logic [15:0] cw, input bit busy);
        int t;
        int lat;
        t = 0;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_start", s_ready, 1);
        rw_drv    = r;
        addr_drv  = a;
        wdata_drv = w;
        cipo_word = cw;
        clear_mon();
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        rw_drv    = 1'($urandom);
        addr_drv  = 7'($urandom);
        wdata_drv = 8'($urandom);
        wait_done(busy, lat);
        start_drv = 1'b0;
        check_frame(r, a, w, lat);
        @(negedge clk);
        chk("done_one_cycle", s_done, 0);
        if (busy) begin
            clear_mon();
            repeat (20) @(negedge clk);
            chk("busy_start_not_queued", ncs_low, 0);
            chk("busy_single_done", done_cnt, 0);
        end
    endtask

    initial begin
        int t;
        int lat;
        logic        r1, r2;
        logic [6:0]  a1, a2;
        logic [7:0]  w1, w2;
        logic [15:0] c1, c2;

        start_drv  = 1'b0;
        rw_drv     = 1'b0;
        addr_drv   = '0;
        wdata_drv  = '0;
        d_sel      = 1'b0;
        rdata_m[0] = '0;
        rdata_m[1] = '0;
        clear_mon();
        hi_run      = 0;
        last_hi_run = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", s_ready, 1);
        chk("rst_done", s_done, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_ncs", s_ncs, 1);
        chk("rst_sclk", s_sclk, 0);
        chk("rst_copi", s_copi, 0);
        rst = 1'b0;
        @(negedge clk);

        do_frame(1'b1, 7'h00, 8'hFF, 16'($urandom), 1'b0);
        do_frame(1'b0, 7'h04, 8'($urandom), {8'($urandom), 8'hA5}, 1'b0);
        do_frame(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b1);

        // Back-to-back with start held high.
        r1 = 1'b0; a1 = 7'($urandom); w1 = 8'($urandom); c1 = 16'($urandom);
        r2 = 1'b1; a2 = ~a1;          w2 = ~w1;          c2 = 16'($urandom);
        rw_drv = r1; addr_drv = a1; wdata_drv = w1; cipo_word = c1;
        clear_mon();
        start_drv = 1'b1;
        @(negedge clk);
        wait_done(1'b0, lat);
        check_frame(r1, a1, w1, lat);
        rw_drv = r2; addr_drv = a2; wdata_drv = w2; cipo_word = c2;
        clear_mon();
        @(negedge clk);
        wait_done(1'b0, lat);
        start_drv = 1'b0;
        check_frame(r2, a2, w2, lat);
        chk("b2b_ncs_high_gap", last_hi_run, 5);

        // Reset during bit 6 of the shift phase.
        repeat (2) @(negedge clk);
        rw_drv = 1'b0; addr_drv = 7'($urandom); wdata_drv = 8'($urandom);
        cipo_word = 16'($urandom);
        clear_mon();
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        t = 0;
        while (rises < 7 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("reached_bit6", rises, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ncs", s_ncs, 1);
        chk("midrst_sclk", s_sclk, 0);
        chk("midrst_copi", s_copi, 0);
        chk("midrst_ready", s_ready, 1);
        chk("midrst_done", s_done, 0);
        rdata_m[0] = '0;
        rdata_m[1] = '0;
        chk("midrst_rdata", s_rdata, rdata_m[0]);
        rst = 1'b0;
        clear_mon();
        repeat (30) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_ncs_idle", ncs_low, 0);
        do_frame(1'b1, 7'($urandom), 8'h5A, 16'($urandom), 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_frame(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b0);
        end

        d_sel = 1'b1;
        @(negedge clk);
        do_frame(1'b1, 7'h7F, 8'h3C, 16'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_frame(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
